module_display_scan: RTL and testbench
======================================

# module_display_scan

Two-digit 7-segment scan driver that sits directly downstream of the data/error display multiplexer. It multiplexes the selected data pattern (digit 0) and an error-status pattern (digit 1) onto one shared segment bus with time-multiplexed active-low anodes. Blanking gaps between digits suppress ghosting, and a blink overlay flags double errors. All inputs are sampled once per scan frame, so a frame never mixes two input states.

## Interface
- `REFRESH_DIV`, default 27000: cycles each digit is lit (1 ms at 27 MHz); legal values ≥ 2.
- `GAP_CYC`, default 27: blanking cycles after each digit; legal values ≥ 1.
- `BLINK_DIV`, default 6750000: cycles per blink half-period (250 ms at 27 MHz); legal values ≥ 2.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `salida_mux`  in  7  digit-0 segment pattern from the display mux; active-high, bit order abcdefg.
- `pos_error`  in  7  digit-1 pattern giving the error position; active-high.
- `error_simple`  in  1  single-error flag.
- `error_doble`  in  1  double-error flag.
- `no_error`  in  1  no-error flag.
- `seg`  out  7  shared segment bus; active-high.
- `anodo`  out  2  digit enables; active-low. Bit 0 is digit 0, bit 1 is digit 1.

## Operation
- **FSM states:** D0, GAP0, D1, GAP1, cycling in that order forever.
- **Phase counter `cnt`:**
  - In D0/D1 it counts 0..REFRESH_DIV-1, then the FSM advances.
  - In GAP0/GAP1 it counts 0..GAP_CYC-1, then the FSM advances.
  - `cnt` clears on every state change.
- **Frame latch:** on each GAP1→D0 edge, capture `salida_mux`, `pos_error` and the three flags. Input changes at any other time have no effect until the next frame.
- **Flag priority** on the latched flags: `error_doble` > `error_simple` > `no_error`. If no flag is set, the mode is "idle".
- **Digit 0 pattern:** latched `salida_mux` in every mode.
- **Digit 1 pattern by mode:**
  - error_simple: latched `pos_error`.
  - error_doble: 7'b0000001 (dash).
  - no_error or idle: 7'b0000000 (blank).
- **Blink:** a free-running counter 0..BLINK_DIV-1 toggles `blink_on` at each wrap.
  - If the latched mode is error_doble and `blink_on`=0, both anodes are deasserted and `seg`=0 in D0 and D1.
  - Otherwise the display is normal.
- **Anodes:**
  - D0: `anodo`=2'b10, `seg`=digit 0 pattern.
  - D1: `anodo`=2'b01, `seg`=digit 1 pattern.
  - GAP0/GAP1: `anodo`=2'b11, `seg`=7'b0000000.
- At most one anode is ever asserted.
- Outputs depend only on registered state (FSM, `cnt`, latch, `blink_on`). There is no combinational path from any input to `seg` or `anodo`.

## Timing
- **Reset state:**
  - FSM = GAP1 with `cnt`=0.
  - Latch = all zeros (idle).
  - Blink counter = 0, `blink_on`=1.
  - `seg`=7'b0000000, `anodo`=2'b11.
- **First frame after reset:** the first D0 entry occurs GAP_CYC cycles after `rst` deasserts, and the latch samples on that edge.
- **Durations:** D0 and D1 last exactly REFRESH_DIV cycles; gaps last exactly GAP_CYC cycles. Frame period = 2·(REFRESH_DIV+GAP_CYC).
- **Input-to-display latency:** from the capturing edge, the new data is visible in the same D0 cycle. Worst case from an input change is one frame period plus one cycle.
- **Reset mid-operation:** `rst` asserted in any state returns everything to the reset state on that edge. There is no partial frame.
- **Simultaneous wraps:** a blink toggle coinciding with a state change is applied on the same edge. The blink state is evaluated per cycle, not per frame.
- **Counter widths:** `$clog2` of the respective divider. Counters never exceed their terminal value.

## Test plan
Parameters for all scenarios: REFRESH_DIV=8, GAP_CYC=2, BLINK_DIV=40.

1. **Reset and no_error:** hold `rst` 3 cycles, then release with `salida_mux`=7'b1111110, `no_error`=1.
   - `anodo`=11 for 2 cycles.
   - Then 8 cycles of `anodo`=10/`seg`=1111110, 2 gap cycles, and 8 cycles of `anodo`=01/`seg`=0000000.
2. **Single error:** `error_simple`=1, `pos_error`=7'b0110000, `salida_mux`=7'b1111110 → in D1, `seg`=0110000 and `anodo`=01; in D0, `seg`=1111110.
3. **Double error with blink:** `error_doble`=1 → in D1, `seg`=0000001 while `blink_on`=1. After 40 cycles from reset, both anodes stay 11 in every state for 40 cycles, then the display resumes.
4. **Mid-frame input change:** change `salida_mux` from 1111110 to 0110000 during D1 → the current frame is unchanged, and the next D0 shows 0110000.
5. **Conflicting flags:** `error_simple`=`error_doble`=`no_error`=1 → double-error behaviour (dash plus blink).
6. **Mid-frame reset:** pulse `rst` during D0 at `cnt`=4 → next cycle `anodo`=11 and `seg`=0, and D0 restarts after 2 cycles with a freshly latched frame.

Source files
------------

// File: rtl/module_display_scan.sv
// Two-digit 7-segment scan driver.
// Digit 0 shows the latched display-mux pattern, digit 1 the error status.
// Blanking gaps separate the digits, and a blink overlay flags double errors.
// Inputs are captured once per frame, on entry to digit 0.
module module_display_scan #(
   parameter int REFRESH_DIV = 27000,
   parameter int GAP_CYC     = 27,
   parameter int BLINK_DIV   = 6750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] salida_mux,
   input  logic [6:0] pos_error,
   input  logic       error_simple,
   input  logic       error_doble,
   input  logic       no_error,
   output logic [6:0] seg,
   output logic [1:0] anodo
);

   localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int BLK_W   = $clog2(BLINK_DIV);

   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {S_D0, S_GAP0, S_D1, S_GAP1} state_t;
   typedef enum logic [1:0] {M_IDLE, M_NOERR, M_SIMPLE, M_DOBLE} mode_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_phase_end;

   logic [6:0]       r_dig0;
   logic [6:0]       r_pos;
   logic             r_err_s;
   logic             r_err_d;
   logic             r_no_err;

   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blink_on;

   mode_t            w_mode;
   logic [6:0]       w_dig1;
   logic             w_blank;

   // Scan FSM state and phase counter; the phase counter restarts on every state change
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_GAP1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_phase_end ? '0 : r_cnt + 1'b1;
      end
   end

   // Frame latch: inputs are captured only on the GAP1 -> D0 edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dig0   <= '0;
         r_pos    <= '0;
         r_err_s  <= 1'b0;
         r_err_d  <= 1'b0;
         r_no_err <= 1'b0;
      end else if (w_phase_end && r_state == S_GAP1) begin
         r_dig0   <= salida_mux;
         r_pos    <= pos_error;
         r_err_s  <= error_simple;
         r_err_d  <= error_doble;
         r_no_err <= no_error;
      end
   end

   // Free-running blink timer, independent of the scan phase
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLK_LAST) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Next-state logic and output decode, driven purely from registered state
   always_comb begin
      w_state_nxt = r_state;
      seg         = 7'b0000000;
      anodo       = 2'b11;
      w_dig1      = 7'b0000000;

      if (r_state == S_D0 || r_state == S_D1) begin
         w_phase_end = (r_cnt == REF_LAST);
      end else begin
         w_phase_end = (r_cnt == GAP_LAST);
      end

      if (w_phase_end) begin
         case (r_state)
            S_D0:    w_state_nxt = S_GAP0;
            S_GAP0:  w_state_nxt = S_D1;
            S_D1:    w_state_nxt = S_GAP1;
            default: w_state_nxt = S_D0;
         endcase
      end

      // Double error dominates single error, which dominates no-error
      if (r_err_d) begin
         w_mode = M_DOBLE;
      end else if (r_err_s) begin
         w_mode = M_SIMPLE;
      end else if (r_no_err) begin
         w_mode = M_NOERR;
      end else begin
         w_mode = M_IDLE;
      end

      case (w_mode)
         M_SIMPLE: w_dig1 = r_pos;
         M_DOBLE:  w_dig1 = 7'b0000001;
         default:  w_dig1 = 7'b0000000;
      endcase

      w_blank = (w_mode == M_DOBLE) && !r_blink_on;

      if (!w_blank) begin
         case (r_state)
            S_D0: begin
               anodo = 2'b10;
               seg   = r_dig0;
            end
            S_D1: begin
               anodo = 2'b01;
               seg   = w_dig1;
            end
            default: begin
               anodo = 2'b11;
               seg   = 7'b0000000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_display_scan.sv
// Bench for module_display_scan: directed scenarios followed by random traffic,
// each cycle checked against a time-based reference model.
module tb_module_display_scan;

   localparam int RD  = 8;
   localparam int GC  = 2;
   localparam int BD  = 40;
   localparam int PER = 2 * (RD + GC);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] salida_mux = '0;
   logic [6:0] pos_error = '0;
   logic       error_simple = 1'b0;
   logic       error_doble = 1'b0;
   logic       no_error = 1'b0;
   logic [6:0] seg;
   logic [1:0] anodo;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: cycles since the reset edge plus the frame's captured inputs
   int         t = 0;
   logic [6:0] m_mux = '0;
   logic [6:0] m_pos = '0;
   logic       m_es = 1'b0;
   logic       m_ed = 1'b0;

   always #5 clk = ~clk;

   module_display_scan #(
      .REFRESH_DIV(RD),
      .GAP_CYC    (GC),
      .BLINK_DIV  (BD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .salida_mux  (salida_mux),
      .pos_error   (pos_error),
      .error_simple(error_simple),
      .error_doble (error_doble),
      .no_error    (no_error),
      .seg         (seg),
      .anodo       (anodo)
   );

   // Offset into the current frame, or -1 before the first digit-0 entry
   function automatic int frame_pos(input int tt);
      if (tt < GC) return -1;
      return (tt - GC) % PER;
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic tick();
      int         p;
      logic       blink_on;
      logic [6:0] e_seg;
      logic [1:0] e_an;
      @(posedge clk);
      if (rst) begin
         t     = 0;
         m_mux = '0;
         m_pos = '0;
         m_es  = 1'b0;
         m_ed  = 1'b0;
      end else begin
         t++;
         if (frame_pos(t) == 0) begin
            m_mux = salida_mux;
            m_pos = pos_error;
            m_es  = error_simple;
            m_ed  = error_doble;
         end
      end
      #1;
      p        = frame_pos(t);
      blink_on = ((t / BD) % 2) == 0;
      e_seg    = 7'b0000000;
      e_an     = 2'b11;
      if (!(m_ed && !blink_on)) begin
         if (p >= 0 && p < RD) begin
            e_an  = 2'b10;
            e_seg = m_mux;
         end else if (p >= RD + GC && p < 2 * RD + GC) begin
            e_an  = 2'b01;
            e_seg = m_ed ? 7'b0000001 : (m_es ? m_pos : 7'b0000000);
         end
      end
      check("seg", seg, e_seg);
      check("anodo", {5'b0, anodo}, {5'b0, e_an});
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   initial begin
      bit found;

      // Reset held for 3 cycles, then no_error with a fixed digit-0 pattern
      rst = 1'b1;
      cycles(3);
      salida_mux = 7'b1111110;
      no_error   = 1'b1;
      rst        = 1'b0;
      cycles(2 * PER);

      // Single error shown at digit 1
      error_simple = 1'b1;
      pos_error    = 7'b0110000;
      no_error     = 1'b0;
      cycles(2 * PER);

      // Double error with blink, timed from a fresh reset
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      error_simple = 1'b0;
      error_doble  = 1'b1;
      cycles(120);

      // Mid-frame data change while digit 1 is lit
      error_doble = 1'b0;
      no_error    = 1'b1;
      cycles(PER);
      found = 1'b0;
      for (int i = 0; i < PER && !found; i++) begin
         if (frame_pos(t) >= RD + GC + 2 && frame_pos(t) < 2 * RD + GC) found = 1'b1;
         else tick();
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $error("FAIL find_d1 t=%0d observed=not_found expected=found", t);
      end
      salida_mux = 7'b0110000;
      cycles(2 * PER);

      // All flags set: double error wins
      error_simple = 1'b1;
      error_doble  = 1'b1;
      no_error     = 1'b1;
      cycles(120);

      // Reset pulse in the middle of digit 0
      error_doble = 1'b0;
      found = 1'b0;
      for (int i = 0; i < PER && !found; i++) begin
         if (frame_pos(t) == 4) found = 1'b1;
         else tick();
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $error("FAIL find_d0 t=%0d observed=not_found expected=found", t);
      end
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      salida_mux = 7'b1011011;
      cycles(2 * PER);

      // Random traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) salida_mux = 7'($urandom);
         if ($urandom_range(0, 7) == 0) pos_error = 7'($urandom);
         if ($urandom_range(0, 15) == 0) error_simple = 1'($urandom);
         if ($urandom_range(0, 15) == 0) error_doble = 1'($urandom);
         if ($urandom_range(0, 15) == 0) no_error = 1'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      cycles(PER);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
